// File: rtl/frame_strobe_gen_if.sv
// ---------------------------------------------------------------------------
// frame_strobe_gen_if
//   Configuration-word write bus feeding frame_strobe_gen.
//
//   Signals
//     WriteData    configuration word (header or frame data row)
//     WriteStrobe  word-valid; one word per high cycle, no back-pressure
//
//   Modports
//     master  word source (drives WriteData / WriteStrobe)
//     slave   word sink   (frame_strobe_gen)
// ---------------------------------------------------------------------------
interface frame_strobe_gen_if #(
  parameter int FrameBitsPerRow = 32
) ();

  logic [FrameBitsPerRow-1:0] WriteData;
  logic                       WriteStrobe;

  modport master (
    output WriteData,
    output WriteStrobe
  );

  modport slave (
    input WriteData,
    input WriteStrobe
  );

endinterface : frame_strobe_gen_if

// File: rtl/frame_strobe_gen.sv
// ---------------------------------------------------------------------------
// frame_strobe_gen
//   Assembles one configuration frame from a stream of words and fires a
//   one-cycle frame strobe with a one-hot frame address.
//
//   Word stream: one header word (column select + frame index) followed by
//   NumberOfRows data words. The cycle after the last data word is the
//   STROBE cycle. A header may arrive in the STROBE cycle itself, so frames
//   can be issued back to back with no idle cycle between them.
//
//   Ports
//     CLK           clock, all state changes on rising edge
//     resetn        asynchronous active-low reset
//     wr            word bus (slave side): WriteData, WriteStrobe
//     FrameData     assembled payload, NumberOfRows slices of FrameBitsPerRow
//     FrameSelect   column number taken from the last header
//     FrameAddress  one-hot frame strobe vector, non-zero only while strobing
//     FrameStrobe   single-cycle frame-write pulse
//     Busy          high whenever a frame is in progress (state != IDLE)
//     Error         sticky: a header carried an out-of-range frame index
// ---------------------------------------------------------------------------
module frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int FrameIndexWidth  = 5,
  parameter int FrameBitsPerRow  = 32,
  parameter int NumberOfRows     = 16
) (
  input  logic                                   CLK,
  input  logic                                   resetn,
  frame_strobe_gen_if.slave                      wr,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [FrameSelectWidth-1:0]            FrameSelect,
  output logic [MaxFramesPerCol-1:0]             FrameAddress,
  output logic                                   FrameStrobe,
  output logic                                   Busy,
  output logic                                   Error
);

  localparam int RowCntWidth = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowCntWidth-1:0] LastRow = RowCntWidth'(NumberOfRows - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [RowCntWidth-1:0]      row_cnt_reg;
  logic [FrameSelectWidth-1:0] frame_select_reg;
  logic [FrameIndexWidth-1:0]  index_reg;
  logic                        index_bad_reg;
  logic                        error_reg;

  // Header fields. Everything between the two fields is don't-care.
  logic [FrameSelectWidth-1:0] hdr_column;
  logic [FrameIndexWidth-1:0]  hdr_index;
  logic                        hdr_bad;
  logic                        unused_write_bits;

  assign hdr_column        = wr.WriteData[FrameBitsPerRow-1 -: FrameSelectWidth];
  assign hdr_index         = wr.WriteData[FrameIndexWidth-1:0];
  assign hdr_bad           = (int'(hdr_index) >= MaxFramesPerCol);
  assign unused_write_bits = ^wr.WriteData;

  // FSM control decode
  logic hdr_accept;
  logic data_accept;
  logic last_word;

  always_comb begin
    state_next  = state_reg;
    hdr_accept  = 1'b0;
    data_accept = 1'b0;
    last_word   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (wr.WriteStrobe) begin
          hdr_accept = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (wr.WriteStrobe) begin
          data_accept = 1'b1;
          if (row_cnt_reg == LastRow) begin
            last_word  = 1'b1;
            state_next = STROBE;
          end
        end
      end
      STROBE: begin
        // A word here already belongs to the next frame.
        if (wr.WriteStrobe) begin
          hdr_accept = 1'b1;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Header capture, row counter and sticky error
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_cnt_reg      <= '0;
      frame_select_reg <= '0;
      index_reg        <= '0;
      index_bad_reg    <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      if (hdr_accept) begin
        frame_select_reg <= hdr_column;
        index_reg        <= hdr_index;
        index_bad_reg    <= hdr_bad;
        row_cnt_reg      <= '0;
        if (hdr_bad) begin
          error_reg <= 1'b1;
        end
      end else if (data_accept && !last_word) begin
        // Counter stops on the last row rather than wrapping.
        row_cnt_reg <= row_cnt_reg + 1'b1;
      end
    end
  end

  // Payload: one register per row slice, written only when its row is up.
  generate
    for (genvar gi = 0; gi < NumberOfRows; gi++) begin : g_row
      logic [FrameBitsPerRow-1:0] slice_reg;
      logic                       slice_we;

      assign slice_we = data_accept && (row_cnt_reg == RowCntWidth'(gi));

      always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
          slice_reg <= '0;
        end else if (slice_we) begin
          slice_reg <= wr.WriteData;
        end
      end

      assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = slice_reg;
    end
  endgenerate

  // An out-of-range frame still spends its STROBE cycle, but silently.
  logic strobe_ok;
  assign strobe_ok = (state_reg == STROBE) && !index_bad_reg;

  generate
    for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_addr
      assign FrameAddress[gi] = strobe_ok && (int'(index_reg) == gi);
    end
  endgenerate

  assign FrameStrobe = strobe_ok;
  assign FrameSelect = frame_select_reg;
  assign Busy        = (state_reg != IDLE);
  assign Error       = error_reg;

endmodule : frame_strobe_gen

// File: tb/tb_frame_strobe_gen.sv
module tb_frame_strobe_gen;

  localparam int W    = 32;
  localparam int ROWS = 16;

  logic            CLK;
  logic            resetn;
  logic [W*ROWS-1:0] FrameData;
  logic [4:0]      FrameSelect;
  logic [19:0]     FrameAddress;
  logic            FrameStrobe;
  logic            Busy;
  logic            Error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int strobes = 0;
  int t_first;

  frame_strobe_gen_if #(.FrameBitsPerRow(W)) wr ();

  frame_strobe_gen dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .wr           (wr.slave),
    .FrameData    (FrameData),
    .FrameSelect  (FrameSelect),
    .FrameAddress (FrameAddress),
    .FrameStrobe  (FrameStrobe),
    .Busy         (Busy),
    .Error        (Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (FrameStrobe) strobes <= strobes + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one word for one cycle; returns #1 after the accepting edge.
  task automatic word(input logic [31:0] d);
    wr.WriteData   = d;
    wr.WriteStrobe = 1'b1;
    @(posedge CLK);
    #1;
    wr.WriteStrobe = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    wr.WriteData   = '0;
    wr.WriteStrobe = 1'b0;
    resetn         = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    chk("rst_fd_zero", {31'b0, |FrameData}, 32'd0);
    chk("rst_sel", {27'b0, FrameSelect}, 32'd0);
    chk("rst_addr", {12'b0, FrameAddress}, 32'd0);
    chk("rst_strobe", {31'b0, FrameStrobe}, 32'd0);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_err", {31'b0, Error}, 32'd0);
    resetn = 1'b1;
    idle_cycle();

    // Frame A: col 18, idx 3, contiguous
    word(32'h9000_0003);
    chk("a_sel", {27'b0, FrameSelect}, 32'd18);
    chk("a_busy", {31'b0, Busy}, 32'd1);
    for (int k = 0; k < ROWS; k++) begin
      if (k == ROWS - 1) chk("a_nostrobe_early", {31'b0, FrameStrobe}, 32'd0);
      word(32'h100 + k);
    end
    chk("a_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("a_addr", {12'b0, FrameAddress}, 32'h0_0008);
    for (int k = 0; k < ROWS; k++) chk($sformatf("a_slice%0d", k), FrameData[k*W +: W], 32'h100 + k);
    idle_cycle();
    chk("a_strobe_off", {31'b0, FrameStrobe}, 32'd0);
    chk("a_addr_off", {12'b0, FrameAddress}, 32'd0);
    chk("a_idle", {31'b0, Busy}, 32'd0);

    // Frame B: same frame, WriteStrobe low on alternate cycles
    word(32'h9000_0003);
    idle_cycle();
    chk("b_busy_gap_hdr", {31'b0, Busy}, 32'd1);
    for (int k = 0; k < ROWS; k++) begin
      word(32'h100 + k);
      if (k < ROWS - 1) begin
        chk($sformatf("b_nostrobe%0d", k), {31'b0, FrameStrobe}, 32'd0);
        idle_cycle();
        chk($sformatf("b_busy%0d", k), {31'b0, Busy}, 32'd1);
      end
    end
    chk("b_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("b_addr", {12'b0, FrameAddress}, 32'h0_0008);
    chk("b_slice0", FrameData[0 +: W], 32'h100);
    chk("b_slice15", FrameData[15*W +: W], 32'h10F);
    idle_cycle();

    // Frames C/D back to back: col 2 idx 0, then col 5 idx 19
    word(32'h1000_0000);
    for (int k = 0; k < ROWS; k++) word(32'h300 + k);
    chk("c_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("c_addr", {12'b0, FrameAddress}, 32'h0_0001);
    chk("c_sel", {27'b0, FrameSelect}, 32'd2);
    t_first = cyc;
    word(32'h2800_0013);
    chk("d_sel", {27'b0, FrameSelect}, 32'd5);
    chk("d_busy", {31'b0, Busy}, 32'd1);
    for (int k = 0; k < ROWS; k++) word(32'h400 + k);
    chk("d_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("d_addr", {12'b0, FrameAddress}, 32'h8_0000);
    chk("d_spacing", cyc - t_first, 32'd17);
    chk("d_slice7", FrameData[7*W +: W], 32'h407);
    idle_cycle();

    // Frame E: index 25 out of range, then valid frame F col 3 idx 7
    word(32'h0800_0019);
    chk("e_err", {31'b0, Error}, 32'd1);
    for (int k = 0; k < ROWS; k++) word(32'h500 + k);
    chk("e_nostrobe", {31'b0, FrameStrobe}, 32'd0);
    chk("e_noaddr", {12'b0, FrameAddress}, 32'd0);
    chk("e_busy_strobe_cycle", {31'b0, Busy}, 32'd1);
    chk("e_slice15", FrameData[15*W +: W], 32'h50F);
    idle_cycle();
    chk("e_idle", {31'b0, Busy}, 32'd0);
    word(32'h1800_0007);
    for (int k = 0; k < ROWS; k++) word(32'h600 + k);
    chk("f_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("f_addr", {12'b0, FrameAddress}, 32'h0_0080);
    chk("f_err_sticky", {31'b0, Error}, 32'd1);
    idle_cycle();

    // Reset after 7 data words aborts the frame
    word(32'h3800_0002);
    for (int k = 0; k < 7; k++) word(32'h700 + k);
    resetn = 1'b0;
    #2;
    chk("r_fd_zero", {31'b0, |FrameData}, 32'd0);
    chk("r_sel", {27'b0, FrameSelect}, 32'd0);
    chk("r_busy", {31'b0, Busy}, 32'd0);
    chk("r_err", {31'b0, Error}, 32'd0);
    chk("r_addr", {12'b0, FrameAddress}, 32'd0);
    idle_cycle();
    #2;
    resetn = 1'b1;
    idle_cycle();
    chk("r_idle_after", {31'b0, Busy}, 32'd0);

    // Frame G: col 4, idx 19 (highest legal index)
    word(32'h2000_0013);
    for (int k = 0; k < ROWS; k++) word(32'h800 + k);
    chk("g_strobe", {31'b0, FrameStrobe}, 32'd1);
    chk("g_addr", {12'b0, FrameAddress}, 32'h8_0000);
    chk("g_err", {31'b0, Error}, 32'd0);
    chk("g_sel", {27'b0, FrameSelect}, 32'd4);
    chk("g_slice3", FrameData[3*W +: W], 32'h803);
    idle_cycle();
    idle_cycle();

    // A, B, C, D, F, G strobe; E and the aborted frame do not
    chk("strobe_total", strobes, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_frame_strobe_gen

// File: doc/frame_strobe_gen.md
FRAME_STROBE_GEN -- requirements
Module: frame_strobe_gen

Interface
- REQ-001 Parameter MaxFramesPerCol, default 20: number of frame strobes per column, i.e. the width of FrameAddress.
- REQ-002 Parameter FrameSelectWidth, default 5: width of the column-select field and of FrameSelect.
- REQ-003 Parameter FrameIndexWidth, default 5: width of the frame-index field in the header word.
- REQ-004 Parameter FrameBitsPerRow, default 32: width of WriteData and of one row slice of FrameData.
- REQ-005 Parameter NumberOfRows, default 16: number of data words per frame.
- REQ-006 CLK  in  1  single clock; all state updates on its rising edge.
- REQ-007 resetn  in  1  asynchronous active-low reset.
- REQ-008 WriteData  in  FrameBitsPerRow  configuration word, qualified by WriteStrobe.
- REQ-009 WriteStrobe  in  1  word-valid; one word is accepted per cycle in which it is high, with no back-pressure.
- REQ-010 FrameData  out  FrameBitsPerRow*NumberOfRows  assembled frame payload.
- REQ-011 FrameSelect  out  FrameSelectWidth  column number for the per-column frame select logic.
- REQ-012 FrameAddress  out  MaxFramesPerCol  one-hot frame strobe vector broadcast to all columns.
- REQ-013 FrameStrobe  out  1  single-cycle frame-write pulse.
- REQ-014 Busy  out  1  high whenever the state is not IDLE.
- REQ-015 Error  out  1  sticky flag for an out-of-range frame index.

Function
- REQ-016 Header word fields:
  - column = WriteData[FrameBitsPerRow-1 -: FrameSelectWidth]
  - index = WriteData[FrameIndexWidth-1:0]
  - all other bits are ignored.
- REQ-017 FSM states: IDLE, LOAD, STROBE.
- REQ-018 IDLE: a word accepted in IDLE is a header.
  - column is registered into FrameSelect; index is registered internally.
  - row counter is cleared to 0; next state is LOAD.
- REQ-019 LOAD: the accepted word with row counter k is written to FrameData[k*FrameBitsPerRow +: FrameBitsPerRow], and the counter increments.
  - Other slices hold their values; cycles with WriteStrobe low leave all state unchanged.
- REQ-020 LOAD to STROBE on acceptance of word k = NumberOfRows-1; the counter does not wrap and is never used beyond NumberOfRows-1.
- REQ-021 STROBE lasts exactly one cycle, which is the cycle after the last data word is accepted.
  - FrameStrobe = 1.
  - FrameAddress = one-hot with bit[index] set.
  - FrameData and FrameSelect are stable.
- REQ-022 Outside STROBE, FrameStrobe = 0 and FrameAddress = 0.
- REQ-023 A word accepted during STROBE is a header for the next frame, handled as in IDLE, so back-to-back frames have no bubble. With no word accepted, the next state is IDLE.
- REQ-024 A header with index >= MaxFramesPerCol:
  - sets Error;
  - its NumberOfRows data words are still consumed into FrameData;
  - the STROBE cycle is still spent, but FrameStrobe = 0 and FrameAddress = 0 in it.
- REQ-025 Error is sticky and is cleared only by resetn.
- REQ-026 FrameSelect holds its value until the next header; FrameData holds its value until overwritten.
- REQ-027 Latency: the last data word accepted in cycle N produces FrameStrobe in cycle N+1.

Reset
- REQ-028 While resetn = 0:
  - state = IDLE, row counter = 0;
  - FrameData = 0, FrameSelect = 0, FrameAddress = 0;
  - FrameStrobe = 0, Busy = 0, Error = 0.
- REQ-029 Reset asserted mid-LOAD or during STROBE aborts the frame immediately (asynchronous), with no strobe. After release, the first accepted word is a header.
- REQ-030 No word is accepted in the cycle in which resetn deasserts.

Verification
- REQ-031 Header 0x9000_0003 followed by 16 words 0x100+k:
  - FrameSelect = 18;
  - one cycle after word 15, FrameStrobe = 1 and FrameAddress = 0x00008 for exactly 1 cycle;
  - slice k = 0x100+k.
- REQ-032 Same frame with WriteStrobe low on alternate cycles -> identical FrameData; the strobe occurs 1 cycle after the 16th data word; Busy is high throughout.
- REQ-033 Two frames back-to-back, the second header arriving in the STROBE cycle of the first (col 2 idx 0, then col 5 idx 19):
  - strobes 17 cycles apart;
  - FrameAddress = 0x00001, then 0x80000;
  - FrameSelect = 2, then 5.
- REQ-034 Header index 25 with 16 data words -> Error = 1 and no FrameStrobe; a following valid frame strobes normally while Error stays 1.
- REQ-035 resetn pulsed low after 7 data words -> all outputs zero and no strobe; a new complete frame then strobes correctly.
- REQ-036 Header index 19 (max legal) -> FrameAddress bit 19 set and Error = 0.
